// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester ports, the memory controller side
//               and the shared completion signals of mem_arbiter.
//               slave  = arbiter view, master = requester / controller view.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  request_0;
  logic                  request_1;
  logic [DATA_WIDTH-1:0] address_0;
  logic [DATA_WIDTH-1:0] address_1;
  logic [DATA_WIDTH-1:0] input_data_0;
  logic [DATA_WIDTH-1:0] input_data_1;
  logic                  should_write_0;
  logic                  should_write_1;
  logic [DATA_WIDTH-1:0] memory_controller_output_data;
  logic                  memory_controller_ready;
  logic [DATA_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_input_data;
  logic                  memory_should_write;
  logic                  memory_request;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  ready_0;
  logic                  ready_1;
  logic                  error;
  logic                  grant;

  modport slave (
    input  request_0, request_1, address_0, address_1,
    input  input_data_0, input_data_1, should_write_0, should_write_1,
    input  memory_controller_output_data, memory_controller_ready,
    output memory_address, memory_input_data, memory_should_write, memory_request,
    output output_data, ready_0, ready_1, error, grant
  );

  modport master (
    output request_0, request_1, address_0, address_1,
    output input_data_0, input_data_1, should_write_0, should_write_1,
    output memory_controller_output_data, memory_controller_ready,
    input  memory_address, memory_input_data, memory_should_write, memory_request,
    input  output_data, ready_0, ready_1, error, grant
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction L1 / data L1) arbiter in front of a
//               single memory controller. IDLE -> BUSY -> DONE -> IDLE, with a
//               BUSY timeout that aborts with a one-cycle error pulse.
//               Macro ARBITER_ROUND_ROBIN_EN: alternate winners on a tie
//               (port 0 first after reset); undefined: port 1 wins ties.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255   // legal range 1..255
) (
  input logic          clock,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [7:0]            r_count;
  logic [DATA_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_write;
  logic                  r_mem_req;
  logic                  r_grant;
  logic                  r_ready_0;
  logic                  r_ready_1;
  logic                  r_error;

  logic                  w_any_req;
  logic                  w_winner;
  logic [7:0]            w_count_inc;

  assign w_any_req   = bus.request_0 | bus.request_1;
  assign w_count_inc = r_count + 8'd1;

`ifdef ARBITER_ROUND_ROBIN_EN
  // Port that was served last; resets to 1 so port 0 is preferred first.
  logic r_last_grant;

  // Tie goes to the port not served last, otherwise to the sole requester.
  always_comb begin
    w_winner = bus.request_1;
    if (bus.request_0 && bus.request_1) w_winner = ~r_last_grant;
  end

  // Remember the winner of every accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_grant <= w_winner;
    end
  end
`else
  // Fixed priority: the data port wins whenever it is requesting.
  always_comb begin
    w_winner = bus.request_1;
  end
`endif

  // Main transaction state machine with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= 8'd0;
      r_address <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_write   <= 1'b0;
      r_mem_req <= 1'b0;
      r_grant   <= 1'b0;
      r_ready_0 <= 1'b0;
      r_ready_1 <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant   <= w_winner;
            r_address <= w_winner ? bus.address_1      : bus.address_0;
            r_wdata   <= w_winner ? bus.input_data_1   : bus.input_data_0;
            r_write   <= w_winner ? bus.should_write_1 : bus.should_write_0;
            r_count   <= 8'd0;
            r_mem_req <= 1'b1;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Completion takes precedence over a timeout in the same cycle.
          if (bus.memory_controller_ready) begin
            if (!r_write) r_rdata <= bus.memory_controller_output_data;
            r_mem_req <= 1'b0;
            r_ready_0 <= ~r_grant;
            r_ready_1 <= r_grant;
            r_state   <= S_DONE;
          end else begin
            r_count <= w_count_inc;
            if (w_count_inc == c_TIMEOUT) begin
              r_mem_req <= 1'b0;
              r_error   <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Pulses last exactly one cycle; always pass through IDLE.
          r_ready_0 <= 1'b0;
          r_ready_1 <= 1'b0;
          r_error   <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.memory_address      = r_address;
  assign bus.memory_input_data   = r_wdata;
  assign bus.memory_should_write = r_write;
  assign bus.memory_request      = r_mem_req;
  assign bus.output_data         = r_rdata;
  assign bus.ready_0             = r_ready_0;
  assign bus.ready_1             = r_ready_1;
  assign bus.error               = r_error;
  assign bus.grant               = r_grant;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32: width of address and data buses.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles before abort; legal range 1..255.
REQ-003 The block SHALL have port clock  in  1: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports request_0, request_1  in  1 each: per-port transaction request, level; port 0 = instruction L1, port 1 = data L1.
REQ-006 The block SHALL have ports address_0, address_1  in  DATA_WIDTH each: per-port transaction address.
REQ-007 The block SHALL have ports input_data_0, input_data_1  in  DATA_WIDTH each: per-port write data.
REQ-008 The block SHALL have ports should_write_0, should_write_1  in  1 each: per-port 1 = write, 0 = read.
REQ-009 The block SHALL have port memory_controller_output_data  in  DATA_WIDTH: read data from the memory controller.
REQ-010 The block SHALL have port memory_controller_ready  in  1: memory controller completion strobe.
REQ-011 The block SHALL have ports memory_address, memory_input_data  out  DATA_WIDTH each, and memory_should_write, memory_request  out  1 each: granted transaction driven to the memory controller.
REQ-012 The block SHALL have port output_data  out  DATA_WIDTH: read data shared by both ports.
REQ-013 The block SHALL have ports ready_0, ready_1  out  1 each: per-port completion pulse.
REQ-014 The block SHALL have port error  out  1: timeout abort pulse.
REQ-015 The block SHALL have port grant  out  1: index of the port owning the current or last transaction.

Function
REQ-016 The state machine SHALL have states IDLE, BUSY and DONE.
REQ-017 IDLE: if either request is high, the block SHALL latch the winner's address, write data and should_write plus the grant index, clear the timeout counter, and go to BUSY next cycle.
REQ-018 BUSY: memory_request SHALL be 1 and the memory_* outputs SHALL show the latched values, held stable until BUSY exits.
REQ-019 BUSY: on memory_controller_ready=1 the block SHALL latch memory_controller_output_data into output_data (reads only; writes leave output_data unchanged) and go to DONE.
REQ-020 BUSY: the counter SHALL increment by one each cycle memory_controller_ready is 0; when it reaches TIMEOUT_CYCLES the block SHALL go to DONE with an abort flag set.
REQ-021 DONE: the block SHALL assert ready_<grant> for exactly one cycle, or assert error for exactly one cycle with no ready if aborted, then return to IDLE.
REQ-022 Latency: request sampled at edge N, memory_request high from N+1, ready sampled at edge M, ready_x high in cycle M+1; minimum request-to-ready is 3 cycles.
REQ-023 Requesters SHALL hold request and operands until their ready or error pulse; operand changes during BUSY SHALL be ignored.
REQ-024 A request dropped during BUSY SHALL NOT cancel the transaction; the ready pulse SHALL still be issued.
REQ-025 DONE SHALL always return to IDLE, never directly to BUSY, so each transaction has one idle cycle of gap.
REQ-026 memory_controller_ready while in IDLE or DONE SHALL be ignored.
REQ-027 Both requests simultaneous: the winner SHALL follow REQ-035 or REQ-036 depending on configuration.

Reset
REQ-028 While reset_n=0 the state SHALL be IDLE and the counter 0.
REQ-029 While reset_n=0 the outputs SHALL be: memory_request, memory_should_write, ready_0, ready_1, error, grant = 0; memory_address, memory_input_data, output_data = 0.
REQ-030 Reset asserted mid-BUSY SHALL abort the transaction silently: no ready pulse and no error pulse.
REQ-031 Arbitration after reset release SHALL start from port 0 as the preferred port.

Configuration
REQ-032 Macro ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-033 Defined: a last-grant register SHALL make the port not served last win a tie.
REQ-034 Undefined: port 1 (data) SHALL always win a tie, and no last-grant register SHALL exist.
REQ-035 With ARBITER_ROUND_ROBIN_EN, simultaneous requests from both ports SHALL alternate winners, port 0 first after reset.
REQ-036 Without ARBITER_ROUND_ROBIN_EN, port 0 SHALL be served only when request_1 is 0 in IDLE.

Verification
REQ-037 Read test: request_0 with address_0=0x40 and should_write_0=0; memory_controller_ready raised 2 cycles into BUSY with data 0xDEADBEEF -> output_data=0xDEADBEEF, ready_0 pulses for 1 cycle, ready_1 stays 0.
REQ-038 Write test: request_1 with address_1=0x80, input_data_1=0x12345678, should_write_1=1 -> memory_address=0x80, memory_input_data=0x12345678, memory_should_write=1 throughout BUSY, ready_1 pulses, output_data unchanged.
REQ-039 Tie test: request_0 and request_1 held high for 4 transactions -> order 0,1,0,1 with the macro defined, 1,1,1,1 without it.
REQ-040 Timeout test: TIMEOUT_CYCLES=8 and memory_controller_ready never asserted -> error pulses once after 8 BUSY cycles, no ready pulse, state returns to IDLE.
REQ-041 Reset test: reset_n pulled low during BUSY then released -> all outputs 0 immediately, no ready or error pulse, next tie granted to port 0.
